// File: rtl/bus_receiver.sv
// Shared-bus receiver: latches the bus word into the strobed destinations and
// tracks bus faults (driver contention, loads from a floating bus) with a sticky error FSM.
module bus_receiver #(
  parameter int BUS_WIDTH   = 16,
  parameter int NUM_DRIVERS = 9,
  parameter int REG8_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [BUS_WIDTH-1:0]   i_bus_data,
  input  logic [NUM_DRIVERS-1:0] i_drive_valid,
  input  logic                   i_a_reg_load,
  input  logic                   i_b_reg_load,
  input  logic                   i_c_reg_load,
  input  logic                   i_t_reg_load,
  input  logic                   i_memory_addr_reg_load,
  input  logic                   i_program_counter_load,
  input  logic                   i_ram_load,
  input  logic                   i_clear_error,
  output logic [REG8_WIDTH-1:0]  o_a_reg,
  output logic [REG8_WIDTH-1:0]  o_b_reg,
  output logic [REG8_WIDTH-1:0]  o_c_reg,
  output logic [REG8_WIDTH-1:0]  o_t_reg,
  output logic [ADDR_WIDTH-1:0]  o_memory_addr_reg,
  output logic [ADDR_WIDTH-1:0]  o_program_counter_load_value,
  output logic                   o_program_counter_load_pulse,
  output logic                   o_ram_wr_en,
  output logic [REG8_WIDTH-1:0]  o_ram_wr_data,
  output logic                   o_error,
  output logic [1:0]             o_error_code,
  output logic [NUM_DRIVERS-1:0] o_error_drivers,
  output logic [7:0]             o_error_count
);

  localparam int EXT_A     = (BUS_WIDTH > ADDR_WIDTH) ? BUS_WIDTH : ADDR_WIDTH;
  localparam int EXT_WIDTH = (EXT_A > REG8_WIDTH) ? EXT_A : REG8_WIDTH;

  localparam logic [1:0] CODE_CONTENTION = 2'b01;
  localparam logic [1:0] CODE_FLOATING   = 2'b10;

  typedef enum logic {
    CLEAN = 1'b0,
    ERROR = 1'b1
  } err_state_t;

  err_state_t state, state_next;

  logic                   contention;
  logic                   any_load;
  logic                   floating;
  logic                   error_event;
  logic                   accept;
  logic [EXT_WIDTH-1:0]   ext_word;
  logic [1:0]             code_next;
  logic [NUM_DRIVERS-1:0] drivers_next;
  logic [7:0]             count_next;
  logic [7:0]             count_inc;

  // Clearing the lowest set bit leaves something behind only if two or more drivers are on.
  assign contention  = |(i_drive_valid & (i_drive_valid - NUM_DRIVERS'(1)));
  assign any_load    = i_a_reg_load | i_b_reg_load | i_c_reg_load | i_t_reg_load |
                       i_memory_addr_reg_load | i_program_counter_load | i_ram_load;
  assign floating    = any_load & ~(|i_drive_valid);
  assign error_event = contention | floating;
  assign accept      = ~contention;
  assign count_inc   = (o_error_count == 8'hFF) ? 8'hFF : o_error_count + 8'd1;
  assign o_error     = (state == ERROR);

  // Zero-extend so each destination can take its low bits whatever the relative widths.
  always_comb begin
    ext_word = '0;
    ext_word[BUS_WIDTH-1:0] = floating ? '0 : i_bus_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a_reg                      <= '0;
      o_b_reg                      <= '0;
      o_c_reg                      <= '0;
      o_t_reg                      <= '0;
      o_memory_addr_reg            <= '0;
      o_program_counter_load_value <= '0;
      o_program_counter_load_pulse <= 1'b0;
      o_ram_wr_en                  <= 1'b0;
      o_ram_wr_data                <= '0;
    end else begin
      o_program_counter_load_pulse <= accept & i_program_counter_load;
      o_ram_wr_en                  <= accept & i_ram_load;
      if (accept) begin
        if (i_a_reg_load)           o_a_reg <= ext_word[REG8_WIDTH-1:0];
        if (i_b_reg_load)           o_b_reg <= ext_word[REG8_WIDTH-1:0];
        if (i_c_reg_load)           o_c_reg <= ext_word[REG8_WIDTH-1:0];
        if (i_t_reg_load)           o_t_reg <= ext_word[REG8_WIDTH-1:0];
        if (i_memory_addr_reg_load) o_memory_addr_reg <= ext_word[ADDR_WIDTH-1:0];
        if (i_program_counter_load) o_program_counter_load_value <= ext_word[ADDR_WIDTH-1:0];
        if (i_ram_load)             o_ram_wr_data <= ext_word[REG8_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= CLEAN;
    else          state <= state_next;
  end

  // A same-cycle error overrides a clear, so the clear is applied first and the event on top.
  always_comb begin
    state_next   = state;
    code_next    = o_error_code;
    drivers_next = o_error_drivers;
    count_next   = o_error_count;
    if (i_clear_error) begin
      state_next   = CLEAN;
      code_next    = '0;
      drivers_next = '0;
      count_next   = '0;
    end
    if (error_event) begin
      state_next = ERROR;
      if (state == CLEAN || i_clear_error) begin
        code_next    = contention ? CODE_CONTENTION : CODE_FLOATING;
        drivers_next = i_drive_valid;
      end
      count_next = i_clear_error ? 8'd1 : count_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_error_code    <= '0;
      o_error_drivers <= '0;
      o_error_count   <= '0;
    end else begin
      o_error_code    <= code_next;
      o_error_drivers <= drivers_next;
      o_error_count   <= count_next;
    end
  end

endmodule

// File: tb/tb_bus_receiver.sv
// Self-checking bench for bus_receiver: a behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_receiver;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus_data;
  logic [8:0]  drive_valid;
  logic        a_load, b_load, c_load, t_load, mar_load, pc_load, ram_load;
  logic        clear_error;

  logic [7:0]  a_reg, b_reg, c_reg, t_reg;
  logic [15:0] mar, pc_value;
  logic        pc_pulse;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_data;
  logic        error;
  logic [1:0]  error_code;
  logic [8:0]  error_drivers;
  logic [7:0]  error_count;

  int assert_count = 0;
  int fail_count   = 0;
  bit check_en     = 0;

  // Reference model state
  logic [7:0]  m_a, m_b, m_c, m_t, m_ram_data;
  logic [15:0] m_mar, m_pc;
  logic        m_pc_pulse, m_ram_en, m_err;
  logic [1:0]  m_code;
  logic [8:0]  m_drv;
  int          m_cnt;
  int          n_drv;
  bit          is_cont, is_float;
  logic [15:0] word;

  bus_receiver dut (
    .i_clk                        (clk),
    .i_rst_n                      (rst_n),
    .i_bus_data                   (bus_data),
    .i_drive_valid                (drive_valid),
    .i_a_reg_load                 (a_load),
    .i_b_reg_load                 (b_load),
    .i_c_reg_load                 (c_load),
    .i_t_reg_load                 (t_load),
    .i_memory_addr_reg_load       (mar_load),
    .i_program_counter_load       (pc_load),
    .i_ram_load                   (ram_load),
    .i_clear_error                (clear_error),
    .o_a_reg                      (a_reg),
    .o_b_reg                      (b_reg),
    .o_c_reg                      (c_reg),
    .o_t_reg                      (t_reg),
    .o_memory_addr_reg            (mar),
    .o_program_counter_load_value (pc_value),
    .o_program_counter_load_pulse (pc_pulse),
    .o_ram_wr_en                  (ram_wr_en),
    .o_ram_wr_data                (ram_wr_data),
    .o_error                      (error),
    .o_error_code                 (error_code),
    .o_error_drivers              (error_drivers),
    .o_error_count                (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a cycle-level restatement of the bus rules, updated on each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_c = 0; m_t = 0; m_ram_data = 0;
      m_mar = 0; m_pc = 0; m_pc_pulse = 0; m_ram_en = 0;
      m_err = 0; m_code = 0; m_drv = 0; m_cnt = 0;
    end else begin
      n_drv    = $countones(drive_valid);
      is_cont  = (n_drv >= 2);
      is_float = (n_drv == 0) && (a_load || b_load || c_load || t_load || mar_load || pc_load || ram_load);
      word     = is_float ? 16'h0000 : bus_data;
      m_pc_pulse = 0;
      m_ram_en   = 0;
      if (!is_cont) begin
        if (a_load)   m_a = word[7:0];
        if (b_load)   m_b = word[7:0];
        if (c_load)   m_c = word[7:0];
        if (t_load)   m_t = word[7:0];
        if (mar_load) m_mar = word;
        if (pc_load)  begin m_pc = word; m_pc_pulse = 1; end
        if (ram_load) begin m_ram_data = word[7:0]; m_ram_en = 1; end
      end
      if (clear_error) begin
        m_err = 0; m_code = 0; m_drv = 0; m_cnt = 0;
      end
      if (is_cont || is_float) begin
        if (!m_err) begin
          m_code = is_cont ? 2'b01 : 2'b10;
          m_drv  = drive_valid;
        end
        m_err = 1;
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("a_reg", 32'(a_reg), 32'(m_a));
    cmp("b_reg", 32'(b_reg), 32'(m_b));
    cmp("c_reg", 32'(c_reg), 32'(m_c));
    cmp("t_reg", 32'(t_reg), 32'(m_t));
    cmp("mem_addr", 32'(mar), 32'(m_mar));
    cmp("pc_value", 32'(pc_value), 32'(m_pc));
    cmp("pc_pulse", 32'(pc_pulse), 32'(m_pc_pulse));
    cmp("ram_wr_en", 32'(ram_wr_en), 32'(m_ram_en));
    cmp("ram_wr_data", 32'(ram_wr_data), 32'(m_ram_data));
    cmp("error", 32'(error), 32'(m_err));
    cmp("error_code", 32'(error_code), 32'(m_code));
    cmp("error_drivers", 32'(error_drivers), 32'(m_drv));
    cmp("error_count", 32'(error_count), 32'(m_cnt));
  endtask

  always @(negedge clk) if (check_en) checkOutput();

  // loads = {ram, pc, mar, t, c, b, a}; inputs change on the falling edge.
  task automatic applyStimulus(input logic [15:0] data, input logic [8:0] dv,
                               input logic [6:0] loads, input logic clr);
    @(negedge clk);
    bus_data    = data;
    drive_valid = dv;
    {ram_load, pc_load, mar_load, t_load, c_load, b_load, a_load} = loads;
    clear_error = clr;
  endtask

  task automatic idle();
    applyStimulus(16'h0000, 9'h000, 7'h00, 1'b0);
  endtask

  logic [8:0] rnd_dv;
  logic [6:0] rnd_loads;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    cmp("reset_error", 32'(error), 0);
    cmp("reset_count", 32'(error_count), 0);
    cmp("reset_a_reg", 32'(a_reg), 0);
    #2 rst_n = 1'b1;
    check_en = 1;

    // Single driver broadcast into A and the address register
    applyStimulus(16'hA55A, 9'h001, 7'b0010001, 1'b0);
    idle();
    cmp("lit_a_reg", 32'(a_reg), 32'h5A);
    cmp("lit_mem_addr", 32'(mar), 32'hA55A);
    cmp("lit_error_clean", 32'(error), 0);

    // Contention suppresses the load and latches the first error
    applyStimulus(16'h1234, 9'h003, 7'b0000010, 1'b0);
    idle();
    cmp("lit_b_hold", 32'(b_reg), 0);
    cmp("lit_cont_error", 32'(error), 1);
    cmp("lit_cont_code", 32'(error_code), 1);
    cmp("lit_cont_drivers", 32'(error_drivers), 32'h003);
    cmp("lit_cont_count", 32'(error_count), 1);

    // Floating RAM load captures zero, code sticks through later contention
    applyStimulus(16'h0000, 9'h000, 7'h00, 1'b1);
    applyStimulus(16'h00C3, 9'h000, 7'b1000000, 1'b0);
    idle();
    cmp("lit_ram_en", 32'(ram_wr_en), 1);
    cmp("lit_ram_data", 32'(ram_wr_data), 0);
    cmp("lit_float_code", 32'(error_code), 2);
    idle();
    cmp("lit_ram_en_drop", 32'(ram_wr_en), 0);
    applyStimulus(16'hFFFF, 9'h1FF, 7'h00, 1'b0);
    idle();
    cmp("lit_code_held", 32'(error_code), 2);
    cmp("lit_count_two", 32'(error_count), 2);

    // Back-to-back program counter loads give back-to-back pulses
    applyStimulus(16'h1111, 9'h010, 7'b0100000, 1'b0);
    applyStimulus(16'h2222, 9'h010, 7'b0100000, 1'b0);
    cmp("lit_pc_pulse1", 32'(pc_pulse), 1);
    cmp("lit_pc_value1", 32'(pc_value), 32'h1111);
    idle();
    cmp("lit_pc_pulse2", 32'(pc_pulse), 1);
    cmp("lit_pc_value2", 32'(pc_value), 32'h2222);
    idle();
    cmp("lit_pc_pulse_off", 32'(pc_pulse), 0);

    // Error count saturation, then clear
    for (int i = 0; i < 300; i++)
      applyStimulus(16'($urandom), 9'h0C0, 7'($urandom), 1'b0);
    idle();
    cmp("lit_count_sat", 32'(error_count), 255);
    applyStimulus(16'h0000, 9'h000, 7'h00, 1'b1);
    idle();
    cmp("lit_clear_error", 32'(error), 0);
    cmp("lit_clear_count", 32'(error_count), 0);
    cmp("lit_clear_code", 32'(error_code), 0);

    // Clear coinciding with contention: the error wins
    applyStimulus(16'h4321, 9'h081, 7'h00, 1'b1);
    idle();
    cmp("lit_clr_cont_error", 32'(error), 1);
    cmp("lit_clr_cont_count", 32'(error_count), 1);
    cmp("lit_clr_cont_code", 32'(error_code), 1);
    cmp("lit_clr_cont_drv", 32'(error_drivers), 32'h081);

    // Asynchronous reset between edges while loaded and in ERROR
    applyStimulus(16'hBE5A, 9'h100, 7'b0000001, 1'b0);
    idle();
    cmp("lit_pre_reset_a", 32'(a_reg), 32'h5A);
    cmp("lit_pre_reset_err", 32'(error), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_a_reg", 32'(a_reg), 0);
    cmp("async_mem_addr", 32'(mar), 0);
    cmp("async_pc_value", 32'(pc_value), 0);
    cmp("async_error", 32'(error), 0);
    cmp("async_code", 32'(error_code), 0);
    cmp("async_drivers", 32'(error_drivers), 0);
    cmp("async_count", 32'(error_count), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(16'h7E81, 9'h004, 7'b0001100, 1'b0);
    idle();
    cmp("lit_post_reset_c", 32'(c_reg), 32'h81);
    cmp("lit_post_reset_t", 32'(t_reg), 32'h81);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:          rnd_dv = 9'h000;
        2, 3, 4, 5, 6: rnd_dv = 9'h001 << $urandom_range(0, 8);
        default:       rnd_dv = 9'($urandom);
      endcase
      rnd_loads = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      applyStimulus(16'($urandom), rnd_dv, rnd_loads, ($urandom_range(0, 15) == 0));
    end
    idle();
    idle();

    check_en = 0;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
